// File: rtl/alu_pkg.sv
// Shared types and constants for the subtractor operand loader.
package alu_pkg;

   typedef enum logic [1:0] {
      LOAD_A = 2'b00,
      LOAD_B = 2'b01,
      EXEC   = 2'b10,
      SHOW   = 2'b11
   } state_t;

   // 10 ms at 50 MHz
   localparam int DEB_CYCLES_DEF = 500000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and a
// single-cycle pulse on the debounced rising edge.
module btn_debounce #(
   parameter int DEB_CYCLES = alu_pkg::DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_pulse
);
   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         cnt       <= '0;
         btn_level <= 1'b0;
         btn_pulse <= 1'b0;
      end else begin
         sync1     <= btn_raw;
         sync2     <= sync1;
         btn_pulse <= 1'b0;
         // Any sample that agrees with the accepted level restarts the count,
         // so a bounce back to the old level discards the partial run.
         if (sync2 == btn_level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            cnt       <= '0;
            btn_level <= sync2;
            btn_pulse <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/operand_loader.sv
// Sequencer that loads A then B from switches for the M-bit subtractor and
// captures its result and status flags for display.
module operand_loader
   import alu_pkg::*;
#(
   parameter int M          = 4,
   parameter int DEB_CYCLES = alu_pkg::DEB_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [M-1:0] sw,
   input  logic         btn_load,
   input  logic         btn_clear,
   output logic [M-1:0] A,
   output logic [M-1:0] B,
   input  logic [M-1:0] R_in,
   output logic [M-1:0] result,
   output logic         flag_z,
   output logic         flag_n,
   output logic         flag_borrow,
   output logic         ops_valid,
   output logic         result_valid,
   output logic [1:0]   state_o
);
   state_t state;
   logic   load_pulse;
   logic   clear_pulse;
   logic   load_level;
   logic   clear_level;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_load),
      .btn_level(load_level), .btn_pulse(load_pulse)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_clear),
      .btn_level(clear_level), .btn_pulse(clear_pulse)
   );

   assign state_o = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= LOAD_A;
         A            <= '0;
         B            <= '0;
         result       <= '0;
         flag_z       <= 1'b0;
         flag_n       <= 1'b0;
         flag_borrow  <= 1'b0;
         ops_valid    <= 1'b0;
         result_valid <= 1'b0;
      end else if (clear_pulse) begin
         // Clear has priority; a coincident load is dropped.
         state        <= LOAD_A;
         A            <= '0;
         B            <= '0;
         result       <= '0;
         flag_z       <= 1'b0;
         flag_n       <= 1'b0;
         flag_borrow  <= 1'b0;
         ops_valid    <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         ops_valid <= 1'b0;
         case (state)
            LOAD_A: if (load_pulse) begin
               A     <= sw;
               state <= LOAD_B;
            end
            LOAD_B: if (load_pulse) begin
               B         <= sw;
               state     <= EXEC;
               ops_valid <= 1'b1;
            end
            EXEC: begin
               result       <= R_in;
               flag_z       <= (R_in == '0);
               flag_n       <= R_in[M-1];
               flag_borrow  <= (A < B);
               result_valid <= 1'b1;
               state        <= SHOW;
            end
            SHOW: if (load_pulse) begin
               A            <= sw;
               B            <= '0;
               result_valid <= 1'b0;
               state        <= LOAD_B;
            end
            default: begin
               result_valid <= 1'b0;
               state        <= LOAD_A;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with M=4, DEB_CYCLES=4 and a modelled subtractor.
module tb_operand_loader;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] sw;
   logic       btn_load;
   logic       btn_clear;
   logic [3:0] A, B, R_in, result;
   logic       flag_z, flag_n, flag_borrow, ops_valid, result_valid;
   logic [1:0] state_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign R_in = A - B;

   operand_loader #(.M(4), .DEB_CYCLES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .btn_load(btn_load), .btn_clear(btn_clear),
      .A(A), .B(B), .R_in(R_in), .result(result),
      .flag_z(flag_z), .flag_n(flag_n), .flag_borrow(flag_borrow),
      .ops_valid(ops_valid), .result_valid(result_valid), .state_o(state_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for the debounced load pulse; returns cycles since call.
   task automatic wait_pulse(input string tag, output int cyc);
      bit found = 0;
      cyc = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (u_dut.load_pulse) begin
            cyc   = i + 1;
            found = 1;
            break;
         end
      end
      chk({tag, "_pulse_seen"}, 32'(found), 32'd1);
   endtask

   task automatic release_btns();
      btn_load  = 1'b0;
      btn_clear = 1'b0;
      repeat (12) step();
   endtask

   task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] er, input logic ez, input logic en, input logic eb);
      int cyc;
      sw = a; btn_load = 1'b1;
      wait_pulse({tag, "_a"}, cyc);
      chk({tag, "_a_lat"}, 32'(cyc), 32'd6);
      step();
      chk({tag, "_a_state"}, 32'(state_o), 32'd1);
      chk({tag, "_a_val"}, 32'(A), 32'(a));
      chk({tag, "_b_zero"}, 32'(B), 32'd0);
      release_btns();
      sw = b; btn_load = 1'b1;
      wait_pulse({tag, "_b"}, cyc);
      step();
      chk({tag, "_exec_state"}, 32'(state_o), 32'd2);
      chk({tag, "_ops_valid"}, 32'(ops_valid), 32'd1);
      chk({tag, "_rv_early"}, 32'(result_valid), 32'd0);
      chk({tag, "_b_val"}, 32'(B), 32'(b));
      step();
      chk({tag, "_show_state"}, 32'(state_o), 32'd3);
      chk({tag, "_rv"}, 32'(result_valid), 32'd1);
      chk({tag, "_ops_drop"}, 32'(ops_valid), 32'd0);
      chk({tag, "_result"}, 32'(result), 32'(er));
      chk({tag, "_z"}, 32'(flag_z), 32'(ez));
      chk({tag, "_n"}, 32'(flag_n), 32'(en));
      chk({tag, "_borrow"}, 32'(flag_borrow), 32'(eb));
      release_btns();
   endtask

   initial begin
      int np;
      int first;
      int cyc;
      rst_n = 1'b0; sw = '0; btn_load = 1'b0; btn_clear = 1'b0;
      repeat (3) step();
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_A", 32'(A), 32'd0);
      chk("rst_B", 32'(B), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_flags", {29'd0, flag_z, flag_n, flag_borrow}, 32'd0);
      chk("rst_valids", {30'd0, ops_valid, result_valid}, 32'd0);
      rst_n = 1'b1;
      repeat (2) step();

      run_op("normal", 4'd9, 4'd3, 4'd6, 1'b0, 1'b0, 1'b0);
      run_op("borrow", 4'd3, 4'd9, 4'hA, 1'b0, 1'b1, 1'b1);
      run_op("zero",   4'd7, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0);

      // Bounce: 2-cycle toggles never satisfy 4 stable samples.
      np = 0;
      sw = 4'd5;
      for (int k = 0; k < 20; k++) begin
         btn_load = ((k / 2) % 2) == 0;
         step();
         if (u_dut.load_pulse) np++;
      end
      chk("bounce_pulses", 32'(np), 32'd0);
      chk("bounce_state", 32'(state_o), 32'd3);

      np = 0; first = 0;
      for (int k = 0; k < 200; k++) begin
         btn_load = 1'b1;
         step();
         if (u_dut.load_pulse) begin
            np++;
            if (first == 0) first = k + 1;
         end
      end
      chk("hold_pulses", 32'(np), 32'd1);
      chk("hold_latency", 32'(first), 32'd6);
      chk("hold_state", 32'(state_o), 32'd1);
      chk("hold_A", 32'(A), 32'd5);
      chk("hold_B", 32'(B), 32'd0);
      release_btns();
      chk("release_state", 32'(state_o), 32'd1);

      // Asynchronous reset between clock edges.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_A", 32'(A), 32'd0);
      chk("async_rst_B", 32'(B), 32'd0);
      chk("async_rst_result", 32'(result), 32'd0);
      chk("async_rst_state", 32'(state_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) step();

      run_op("pre_clear", 4'd9, 4'd3, 4'd6, 1'b0, 1'b0, 1'b0);
      sw = 4'd12; btn_load = 1'b1; btn_clear = 1'b1;
      wait_pulse("clr", cyc);
      chk("clr_coincident", 32'(u_dut.clear_pulse), 32'd1);
      step();
      chk("clr_state", 32'(state_o), 32'd0);
      chk("clr_A", 32'(A), 32'd0);
      chk("clr_B", 32'(B), 32'd0);
      chk("clr_result", 32'(result), 32'd0);
      chk("clr_flags", {29'd0, flag_z, flag_n, flag_borrow}, 32'd0);
      chk("clr_rv", 32'(result_valid), 32'd0);
      repeat (5) step();
      chk("clr_hold_A", 32'(A), 32'd0);
      chk("clr_hold_state", 32'(state_o), 32'd0);
      release_btns();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
